level_object_table: RTL and testbench

- Parametrised registry of grabbable objects for a Gold Miner level. Each entry holds an element type and a grid cell index.
- Supports insert, hit-query by grid index, grab (query and remove) and clear through a valid/ready command port.
- Sits between the level loader / hook-collision logic and the drawing and score logic.
- Generalises the fixed 20-object, 15x20-grid metadata record to configurable depth, grid size and type width, and adds sequential lookup/removal.

---
 rtl/level_object_table_pkg.sv | 39 +++
 rtl/level_object_free_slot_finder.sv | 25 ++
 rtl/level_object_table.sv | 200 ++++++++++++++++++++
 tb/tb_level_object_table.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_object_table_pkg.sv
// Shared types and defaults for the Gold Miner level object table.
package level_object_table_pkg;

  localparam int DEF_MAX_OBJECTS = 20;
  localparam int DEF_GRID_ROWS   = 15;
  localparam int DEF_GRID_COLS   = 20;
  localparam int DEF_TYPE_W      = 3;
  localparam int DEF_IDX_W       = 9;

  // Element kinds; FILLER (0) marks an empty cell and is never stored.
  typedef enum logic [DEF_TYPE_W-1:0] {
    FILLER     = 3'd0,
    GOLD_SMALL = 3'd1,
    GOLD_BIG   = 3'd2,
    DIAMOND    = 3'd3,
    ROCK_SMALL = 3'd4,
    ROCK_BIG   = 3'd5,
    BAG        = 3'd6,
    TNT        = 3'd7
  } LEVEL_ELEMENTS;

  typedef struct packed {
    LEVEL_ELEMENTS          kind;
    logic [DEF_IDX_W-1:0]   index;
  } GRABBABLE_OBJECT_METADATA;

  typedef enum logic [1:0] {
    OP_INSERT = 2'd0,
    OP_QUERY  = 2'd1,
    OP_GRAB   = 2'd2,
    OP_CLEAR  = 2'd3
  } TABLE_OP;

  // Gold and diamonds (types 1..3) are the objects that score points.
  function automatic logic is_valuable(input logic [31:0] kind);
    return (kind >= 32'd1) && (kind <= 32'd3);
  endfunction

endpackage

// File: rtl/level_object_free_slot_finder.sv
// Combinational priority encoder: lowest-numbered free table slot.
module level_object_free_slot_finder
  import level_object_table_pkg::*;
#(
  parameter int MAX_OBJECTS = DEF_MAX_OBJECTS,
  parameter int SLOT_W      = $clog2(MAX_OBJECTS)
) (
  input  logic [MAX_OBJECTS-1:0] slot_valid,
  output logic [SLOT_W-1:0]      free_slot,
  output logic                   none_free
);

  // Walk from the top slot down so the lowest free slot is the last one written.
  always_comb begin
    free_slot = '0;
    none_free = 1'b1;
    for (int i = MAX_OBJECTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        free_slot = SLOT_W'(i);
        none_free = 1'b0;
      end
    end
  end

endmodule

// File: rtl/level_object_table.sv
// Registry of grabbable level objects with insert / query / grab / clear.
// Optional macro LEVEL_OBJECT_TABLE_TYPE_COUNT_EN adds the valuables_left counter.
module level_object_table
  import level_object_table_pkg::*;
#(
  parameter int MAX_OBJECTS = DEF_MAX_OBJECTS,
  parameter int GRID_ROWS   = DEF_GRID_ROWS,
  parameter int GRID_COLS   = DEF_GRID_COLS,
  parameter int TYPE_W      = DEF_TYPE_W,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int SLOT_W      = $clog2(MAX_OBJECTS)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [TYPE_W-1:0] cmd_type,
  input  logic [IDX_W-1:0]  cmd_index,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic [SLOT_W-1:0] rsp_slot,
  output logic [TYPE_W-1:0] rsp_type,
  output logic [SLOT_W:0]   obj_count,
  output logic              full,
  output logic              empty
`ifdef LEVEL_OBJECT_TABLE_TYPE_COUNT_EN
  ,
  output logic [SLOT_W:0]   valuables_left
`endif
);

  localparam logic [IDX_W:0]    NUM_CELLS = (IDX_W+1)'(GRID_ROWS * GRID_COLS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MAX_OBJECTS - 1);
  localparam logic [SLOT_W:0]   COUNT_MAX = (SLOT_W+1)'(MAX_OBJECTS);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} state_e;

  state_e state, state_next;

  logic [MAX_OBJECTS-1:0] slot_valid;
  logic [TYPE_W-1:0]      slot_type  [MAX_OBJECTS];
  logic [IDX_W-1:0]       slot_index [MAX_OBJECTS];

  TABLE_OP           op_q;
  logic [IDX_W-1:0]  index_q;
  logic [SLOT_W-1:0] scan_slot;
  logic [SLOT_W-1:0] free_slot;
  logic              none_free;

  TABLE_OP           cur_op;
  logic              accept, index_bad, insert_ok, insert_err, clear_all;
  logic              scan_match, grab_remove;
  logic              nxt_hit, nxt_err;
  logic [SLOT_W-1:0] nxt_slot;
  logic [TYPE_W-1:0] nxt_type;
  logic [SLOT_W:0]   count_next;
`ifdef LEVEL_OBJECT_TABLE_TYPE_COUNT_EN
  logic [SLOT_W:0]   valuables_next;
`endif

  level_object_free_slot_finder #(
    .MAX_OBJECTS (MAX_OBJECTS),
    .SLOT_W      (SLOT_W)
  ) u_free_slot (
    .slot_valid (slot_valid),
    .free_slot  (free_slot),
    .none_free  (none_free)
  );

  // Next-state, table-update strobes and the response that will be shown in RESP.
  always_comb begin
    state_next  = state;
    cmd_ready   = (state == ST_IDLE);
    cur_op      = TABLE_OP'(cmd_op);
    accept      = cmd_valid && (state == ST_IDLE);
    index_bad   = ({1'b0, cmd_index} >= NUM_CELLS);
    insert_err  = accept && (cur_op == OP_INSERT) && ((cmd_type == '0) || index_bad);
    insert_ok   = accept && (cur_op == OP_INSERT) && !insert_err && !none_free;
    clear_all   = accept && (cur_op == OP_CLEAR);
    scan_match  = (state == ST_SCAN) && slot_valid[scan_slot] && (slot_index[scan_slot] == index_q);
    grab_remove = (state == ST_RESP) && rsp_hit && (op_q == OP_GRAB);
    nxt_hit     = 1'b0;
    nxt_err     = 1'b0;
    nxt_slot    = '0;
    nxt_type    = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cur_op == OP_INSERT) begin
            state_next = ST_RESP;
            nxt_hit    = insert_ok;
            nxt_err    = insert_err;
            if (insert_ok) begin
              nxt_slot = free_slot;
              nxt_type = cmd_type;
            end
          end else if (cur_op == OP_CLEAR) begin
            state_next = ST_RESP;
          end else if (index_bad) begin
            state_next = ST_RESP;
            nxt_err    = 1'b1;
          end else begin
            state_next = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (scan_match) begin
          state_next = ST_RESP;
          nxt_hit    = 1'b1;
          nxt_slot   = scan_slot;
          nxt_type   = slot_type[scan_slot];
        end else if (scan_slot == LAST_SLOT) begin
          state_next = ST_RESP;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    count_next = obj_count;
    if (clear_all)        count_next = '0;
    else if (insert_ok)   count_next = obj_count + 1'b1;
    else if (grab_remove) count_next = obj_count - 1'b1;

`ifdef LEVEL_OBJECT_TABLE_TYPE_COUNT_EN
    valuables_next = valuables_left;
    if (clear_all)
      valuables_next = '0;
    else if (insert_ok && is_valuable(32'(cmd_type)))
      valuables_next = valuables_left + 1'b1;
    else if (grab_remove && is_valuable(32'(rsp_type)))
      valuables_next = valuables_left - 1'b1;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Command capture, scan pointer, valid bits, counters and response registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      op_q       <= OP_INSERT;
      index_q    <= '0;
      scan_slot  <= '0;
      slot_valid <= '0;
      obj_count  <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_slot   <= '0;
      rsp_type   <= '0;
    end else begin
      if (accept) begin
        op_q      <= cur_op;
        index_q   <= cmd_index;
        scan_slot <= '0;
      end else if (state == ST_SCAN) begin
        scan_slot <= scan_slot + 1'b1;
      end
      if (clear_all) begin
        slot_valid <= '0;
      end else begin
        if (insert_ok)   slot_valid[free_slot] <= 1'b1;
        if (grab_remove) slot_valid[rsp_slot]  <= 1'b0;
      end
      obj_count <= count_next;
      full      <= (count_next == COUNT_MAX);
      empty     <= (count_next == '0);
      rsp_valid <= (state_next == ST_RESP);
      rsp_hit   <= (state_next == ST_RESP) && nxt_hit;
      rsp_err   <= (state_next == ST_RESP) && nxt_err;
      rsp_slot  <= (state_next == ST_RESP) ? nxt_slot : '0;
      rsp_type  <= (state_next == ST_RESP) ? nxt_type : '0;
    end
  end

  // Slot payload; contents of invalid slots are never looked at, so no reset.
  always_ff @(posedge clk) begin
    if (insert_ok) begin
      slot_type[free_slot]  <= cmd_type;
      slot_index[free_slot] <= cmd_index;
    end
  end

`ifdef LEVEL_OBJECT_TABLE_TYPE_COUNT_EN
  // Count of stored gold and diamonds, tracking obj_count timing.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) valuables_left <= '0;
    else         valuables_left <= valuables_next;
  end
`endif

endmodule

// File: tb/tb_level_object_table.sv
// Self-checking bench for level_object_table with a table-level reference model.
module tb_level_object_table;

  localparam int MAXO  = 20;
  localparam int CELLS = 300;

  logic       clk       = 1'b0;
  logic       resetN    = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op    = 2'd0;
  logic [2:0] cmd_type  = 3'd0;
  logic [8:0] cmd_index = 9'd0;
  logic       rsp_valid, rsp_hit, rsp_err;
  logic [4:0] rsp_slot;
  logic [2:0] rsp_type;
  logic [5:0] obj_count;
  logic       full, empty;
`ifdef LEVEL_OBJECT_TABLE_TYPE_COUNT_EN
  logic [5:0] valuables_left;
`endif

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;
  bit checking = 1'b0;

  bit m_valid [MAXO];
  int m_type  [MAXO];
  int m_index [MAXO];

  bit exp_pending = 1'b0;
  int exp_rsp_cyc = 0;
  int e_hit = 0, e_err = 0, e_slot = 0, e_type = 0;
  int grab_slot = -1;
  int last_t_acc = 0;
  int got_cyc = 0, got_hit = 0, got_err = 0, got_slot = 0, got_type = 0;
  int rsp_seen = 0;
  bit cmp_busy, cmp_resp;

  level_object_table dut (
    .clk       (clk),
    .resetN    (resetN),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_type  (cmd_type),
    .cmd_index (cmd_index),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_err   (rsp_err),
    .rsp_slot  (rsp_slot),
    .rsp_type  (rsp_type),
    .obj_count (obj_count),
    .full      (full),
    .empty     (empty)
`ifdef LEVEL_OBJECT_TABLE_TYPE_COUNT_EN
    ,
    .valuables_left (valuables_left)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < MAXO; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic int model_valuables();
    int n = 0;
    for (int i = 0; i < MAXO; i++)
      if (m_valid[i] && (m_type[i] >= 1) && (m_type[i] <= 3)) n++;
    return n;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < MAXO; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept one command and work out from the table contents when and what the DUT answers.
  task automatic issueCommand(input int op, input int ty, input int idx);
    int k;
    int lat;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_type  = 3'(ty);
    cmd_index = 9'(idx);
    @(posedge clk);
    #1;
    last_t_acc = cyc - 1;
    rsp_seen   = 0;
    cmd_valid  = 1'($urandom_range(0, 1));
    cmd_op     = 2'($urandom);
    cmd_type   = 3'($urandom);
    cmd_index  = 9'($urandom);
    e_hit = 0; e_err = 0; e_slot = 0; e_type = 0; grab_slot = -1; lat = 1;
    if (op == 0) begin
      if ((ty == 0) || (idx >= CELLS)) begin
        e_err = 1;
      end else begin
        k = -1;
        for (int i = MAXO - 1; i >= 0; i--) if (!m_valid[i]) k = i;
        if (k >= 0) begin
          e_hit = 1; e_slot = k; e_type = ty;
          m_valid[k] = 1'b1; m_type[k] = ty; m_index[k] = idx;
        end
      end
    end else if (op == 3) begin
      model_clear();
    end else if (idx >= CELLS) begin
      e_err = 1;
    end else begin
      k = -1;
      for (int i = MAXO - 1; i >= 0; i--) if (m_valid[i] && (m_index[i] == idx)) k = i;
      if (k >= 0) begin
        e_hit = 1; e_slot = k; e_type = m_type[k]; lat = k + 2;
        if (op == 2) grab_slot = k;
      end else begin
        lat = MAXO + 1;
      end
    end
    exp_rsp_cyc = last_t_acc + lat;
    exp_pending = 1'b1;
  endtask

  // Let the response cycle pass, then retire a grabbed entry from the model.
  task automatic waitResponse();
    while (cyc <= exp_rsp_cyc) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (grab_slot >= 0) m_valid[grab_slot] = 1'b0;
    grab_slot   = -1;
    exp_pending = 1'b0;
  endtask

  task automatic applyStimulus(input int op, input int ty, input int idx);
    issueCommand(op, ty, idx);
    waitResponse();
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (checking) begin
      cmp_busy = exp_pending && (cyc <= exp_rsp_cyc);
      cmp_resp = exp_pending && (cyc == exp_rsp_cyc);
      checkOutput("cmd_ready", int'(cmd_ready), cmp_busy ? 0 : 1);
      checkOutput("rsp_valid", int'(rsp_valid), int'(cmp_resp));
      checkOutput("rsp_hit",   int'(rsp_hit),   cmp_resp ? e_hit  : 0);
      checkOutput("rsp_err",   int'(rsp_err),   cmp_resp ? e_err  : 0);
      checkOutput("rsp_slot",  int'(rsp_slot),  cmp_resp ? e_slot : 0);
      checkOutput("rsp_type",  int'(rsp_type),  cmp_resp ? e_type : 0);
      checkOutput("obj_count", int'(obj_count), model_count());
      checkOutput("full",      int'(full),      (model_count() == MAXO) ? 1 : 0);
      checkOutput("empty",     int'(empty),     (model_count() == 0) ? 1 : 0);
`ifdef LEVEL_OBJECT_TABLE_TYPE_COUNT_EN
      checkOutput("valuables_left", int'(valuables_left), model_valuables());
`endif
      if (rsp_valid === 1'b1) begin
        rsp_seen++;
        got_cyc  = cyc;
        got_hit  = int'(rsp_hit);
        got_err  = int'(rsp_err);
        got_slot = int'(rsp_slot);
        got_type = int'(rsp_type);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, op, ty, idx;
    #2 resetN = 1'b0;
    #1 checking = 1'b1;
    repeat (3) @(negedge clk);
    #2 resetN = 1'b1;
    @(negedge clk);
    checkOutput("reset_obj_count", int'(obj_count), 0);
    checkOutput("reset_empty",     int'(empty),     1);
    checkOutput("reset_full",      int'(full),      0);
    checkOutput("reset_cmd_ready", int'(cmd_ready), 1);

    applyStimulus(0, 1, 45);
    checkOutput("ins45_seen",    rsp_seen, 1);
    checkOutput("ins45_latency", got_cyc - last_t_acc, 1);
    checkOutput("ins45_hit",     got_hit, 1);
    checkOutput("ins45_slot",    got_slot, 0);
    checkOutput("ins45_count",   int'(obj_count), 1);
    checkOutput("ins45_empty",   int'(empty), 0);

    applyStimulus(3, 0, 0);
    checkOutput("clear_count", int'(obj_count), 0);

    for (int i = 0; i < MAXO; i++) applyStimulus(0, (i == 7) ? 2 : (i % 5) + 1, i);
    applyStimulus(0, 3, 100);
    checkOutput("full_ins_hit",   got_hit, 0);
    checkOutput("full_ins_err",   got_err, 0);
    checkOutput("full_flag",      int'(full), 1);
    checkOutput("full_count",     int'(obj_count), 20);

    applyStimulus(1, 0, 7);
    checkOutput("query7_latency", got_cyc - last_t_acc, 9);
    checkOutput("query7_hit",     got_hit, 1);
    checkOutput("query7_slot",    got_slot, 7);
    checkOutput("query7_type",    got_type, 2);
    checkOutput("query7_count",   int'(obj_count), 20);

    applyStimulus(2, 0, 7);
    checkOutput("grab7_latency",  got_cyc - last_t_acc, 9);
    checkOutput("grab7_hit",      got_hit, 1);
    checkOutput("grab7_slot",     got_slot, 7);
    checkOutput("grab7_count",    int'(obj_count), 19);

    applyStimulus(2, 0, 7);
    checkOutput("regrab7_latency", got_cyc - last_t_acc, 21);
    checkOutput("regrab7_hit",     got_hit, 0);

    applyStimulus(1, 0, 300);
    checkOutput("query300_latency", got_cyc - last_t_acc, 1);
    checkOutput("query300_err",     got_err, 1);

    applyStimulus(0, 0, 50);
    checkOutput("filler_err",   got_err, 1);
    checkOutput("filler_count", int'(obj_count), 19);

    issueCommand(1, 0, 299);
    while (cyc < last_t_acc + 6) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #2;
    resetN      = 1'b0;
    cmd_valid   = 1'b0;
    exp_pending = 1'b0;
    grab_slot   = -1;
    model_clear();
    repeat (2) @(negedge clk);
    #2 resetN = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("abort_no_rsp",    rsp_seen, 0);
    checkOutput("abort_count",     int'(obj_count), 0);
    checkOutput("abort_cmd_ready", int'(cmd_ready), 1);

`ifdef LEVEL_OBJECT_TABLE_TYPE_COUNT_EN
    applyStimulus(0, 1, 10);
    applyStimulus(0, 2, 11);
    applyStimulus(0, 3, 12);
    applyStimulus(0, 4, 13);
    checkOutput("valuables_after_inserts", int'(valuables_left), 3);
    applyStimulus(3, 0, 0);
    checkOutput("valuables_after_clear", int'(valuables_left), 0);
`endif

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 99);
      op = (r < 40) ? 0 : (r < 65) ? 1 : (r < 90) ? 2 : 3;
      ty = $urandom_range(0, 7);
      r  = $urandom_range(0, 99);
      if (r < 70)      idx = $urandom_range(0, 24);
      else if (r < 85) idx = $urandom_range(280, 299);
      else             idx = $urandom_range(300, 511);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(op, ty, idx);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
